// File: rtl/sync_cycle_tracker.sv
// sync_cycle_tracker: recovers the MCS-4 subcycle (A1..X3) from clk1/clk2/sync and captures address/instruction nibbles
//   sysclk, reset            : system clock, asynchronous active-high reset
//   clk1, clk2, sync, d_in   : CPU phase levels, SYNC and 4-bit data bus
//   a1..x3, subcycle         : one-hot and encoded current subcycle
//   tracking, locked         : counter running / LOCK_CYCLES good syncs seen
//   addr, addr_valid         : 12-bit address and completion pulse
//   inst, inst_valid         : 8-bit instruction and completion pulse
//   sync_error               : pulse on a misplaced or missing sync
module sync_cycle_tracker #(
  parameter int LOCK_CYCLES = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        clk1,
  input  logic        clk2,
  input  logic        sync,
  input  logic [3:0]  d_in,
  output logic        a1,
  output logic        a2,
  output logic        a3,
  output logic        m1,
  output logic        m2,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic [2:0]  subcycle,
  output logic        tracking,
  output logic        locked,
  output logic [11:0] addr,
  output logic        addr_valid,
  output logic [7:0]  inst,
  output logic        inst_valid,
  output logic        sync_error
);
  logic       clk1_q, clk2_q;
  logic [3:0] good;
  logic [7:0] hot;
  logic       rise1, fall2;
  logic [2:0] nxt;
  logic [3:0] good_inc;
  assign rise1    = clk1 & ~clk1_q;
  assign fall2    = ~clk2 & clk2_q;
  assign nxt      = subcycle + 3'd1;
  assign good_inc = good == 4'd15 ? 4'd15 : good + 4'd1;
  assign {x3, x2, x1, m2, m1, a3, a2, a1} = hot;
  always_ff @(posedge sysclk or posedge reset)
    if (reset) begin
      clk1_q     <= 1'b0;
      clk2_q     <= 1'b0;
      good       <= 4'd0;
      hot        <= 8'd0;
      subcycle   <= 3'd0;
      tracking   <= 1'b0;
      locked     <= 1'b0;
      addr       <= 12'd0;
      inst       <= 8'd0;
      addr_valid <= 1'b0;
      inst_valid <= 1'b0;
      sync_error <= 1'b0;
    end else begin
      clk1_q     <= clk1;
      clk2_q     <= clk2;
      sync_error <= 1'b0;
      addr_valid <= 1'b0;
      inst_valid <= 1'b0;
      // rise1 has priority; a coincident fall2 capture is dropped
      if (rise1) begin
        if (!tracking) begin
          if (sync) begin
            tracking <= 1'b1;
            subcycle <= 3'd7;
            hot      <= 8'h80;
          end
        end else if (sync) begin
          // sync always forces X3; it only counts as good when it lands where expected
          subcycle <= 3'd7;
          hot      <= 8'h80;
          if (nxt == 3'd7) begin
            good   <= good_inc;
            locked <= good_inc >= 4'(LOCK_CYCLES);
          end else begin
            sync_error <= 1'b1;
            good       <= 4'd0;
            locked     <= 1'b0;
          end
        end else if (nxt != 3'd7) begin
          subcycle <= nxt;
          hot      <= 8'd1 << nxt;
        end else begin
          sync_error <= 1'b1;
          tracking   <= 1'b0;
          locked     <= 1'b0;
          good       <= 4'd0;
          hot        <= 8'd0;
          subcycle   <= 3'd0;
        end
      end else if (fall2 && tracking) begin
        if (subcycle == 3'd0) addr[3:0]  <= d_in;
        if (subcycle == 3'd1) addr[7:4]  <= d_in;
        if (subcycle == 3'd2) addr[11:8] <= d_in;
        if (subcycle == 3'd3) inst[7:4]  <= d_in;
        if (subcycle == 3'd4) inst[3:0]  <= d_in;
        addr_valid <= subcycle == 3'd2 && locked;
        inst_valid <= subcycle == 3'd4 && locked;
      end
    end
endmodule

// File: tb/tb_sync_cycle_tracker.sv
// tb_sync_cycle_tracker: table-driven scoreboard bench for sync_cycle_tracker (LOCK_CYCLES=2 and =1 side by side)
module tb_sync_cycle_tracker;
  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        clk1 = 1'b0, clk2 = 1'b0, sync = 1'b0;
  logic [3:0]  d_in = 4'd0;
  logic [7:0]  hot, hot_b;
  logic [2:0]  subcycle, subcycle_b;
  logic        tracking, locked, addr_valid, inst_valid, sync_error;
  logic        tracking_b, locked_b, addr_valid_b, inst_valid_b, sync_error_b;
  logic [11:0] addr, addr_b;
  logic [7:0]  inst, inst_b;
  int errors = 0;
  int checks = 0;

  always #5 sysclk = ~sysclk;

  sync_cycle_tracker #(.LOCK_CYCLES(2)) dut (
    .sysclk(sysclk), .reset(reset), .clk1(clk1), .clk2(clk2), .sync(sync), .d_in(d_in),
    .a1(hot[0]), .a2(hot[1]), .a3(hot[2]), .m1(hot[3]), .m2(hot[4]), .x1(hot[5]), .x2(hot[6]), .x3(hot[7]),
    .subcycle(subcycle), .tracking(tracking), .locked(locked), .addr(addr), .addr_valid(addr_valid),
    .inst(inst), .inst_valid(inst_valid), .sync_error(sync_error)
  );

  sync_cycle_tracker #(.LOCK_CYCLES(1)) dut1 (
    .sysclk(sysclk), .reset(reset), .clk1(clk1), .clk2(clk2), .sync(sync), .d_in(d_in),
    .a1(hot_b[0]), .a2(hot_b[1]), .a3(hot_b[2]), .m1(hot_b[3]), .m2(hot_b[4]), .x1(hot_b[5]), .x2(hot_b[6]), .x3(hot_b[7]),
    .subcycle(subcycle_b), .tracking(tracking_b), .locked(locked_b), .addr(addr_b), .addr_valid(addr_valid_b),
    .inst(inst_b), .inst_valid(inst_valid_b), .sync_error(sync_error_b)
  );

  typedef struct {
    logic [3:0] d;
    logic       s;
    logic [2:0] sc;
    logic       trk;
    logic       lck;
    logic       lck1;
    logic       err;
    logic       av;
    logic       iv;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(logic [3:0] d, logic s, logic [2:0] sc, logic trk, logic lck, logic lck1, logic err, logic av, logic iv);
    tbl.push_back(vec_t'{d, s, sc, trk, lck, lck1, err, av, iv});
  endfunction

  function automatic void add_cycle(logic lk, logic lk1, logic v, logic xs, logic xt, logic xl, logic xl1, logic xe);
    add(4'h3, 0, 3'd0, 1, lk, lk1, 0, 0, 0);
    add(4'h5, 0, 3'd1, 1, lk, lk1, 0, 0, 0);
    add(4'h9, 0, 3'd2, 1, lk, lk1, 0, v, 0);
    add(4'hc, 0, 3'd3, 1, lk, lk1, 0, 0, 0);
    add(4'h6, 0, 3'd4, 1, lk, lk1, 0, 0, v);
    add(4'h0, 0, 3'd5, 1, lk, lk1, 0, 0, 0);
    add(4'h0, 0, 3'd6, 1, lk, lk1, 0, 0, 0);
    add(4'h0, xs, 3'd7, xt, xl, xl1, xe, 0, 0);
  endfunction

  task automatic phase(input int k);
    @(negedge sysclk);
    clk1 = k < 2;
    clk2 = k >= 4 && k < 6;
    @(posedge sysclk);
    #1;
  endtask

  task automatic run(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    sync = v.s;
    d_in = v.d;
    phase(0);
    e = exp_q.pop_front();
    chk("tracking", tracking, e.trk);
    chk("locked", locked, e.lck);
    chk("locked_l1", locked_b, e.lck1);
    chk("sync_error", sync_error, e.err);
    chk("onehot", hot, e.trk ? 8'd1 << e.sc : 8'd0);
    if (e.trk) chk("subcycle", subcycle, e.sc);
    chk("valid_idle", {addr_valid, inst_valid}, 0);
    for (int k = 1; k < 6; k++) phase(k);
    phase(6);
    chk("addr_valid", addr_valid, e.av);
    chk("inst_valid", inst_valid, e.iv);
    if (e.av) chk("addr", addr, 12'h953);
    if (e.iv) chk("inst", inst, 8'hc6);
    phase(7);
    if (e.trk) chk("subcycle_hold", subcycle, e.sc);
    chk("valid_pulse", {addr_valid, inst_valid}, 0);
  endtask

  initial begin
    repeat (2) @(posedge sysclk);
    #1;
    chk("reset_state", {hot, subcycle, tracking, locked, addr, addr_valid, inst, inst_valid, sync_error}, 0);
    @(negedge sysclk);
    reset = 1'b0;
    // lock-in, locked operation, early sync, missing sync and recovery
    add(4'h0, 1, 3'd7, 1, 0, 0, 0, 0, 0);
    add_cycle(0, 0, 0, 1, 1, 0, 1, 0);
    add_cycle(0, 1, 0, 1, 1, 1, 1, 0);
    add_cycle(1, 1, 1, 1, 1, 1, 1, 0);
    add(4'h3, 0, 3'd0, 1, 1, 1, 0, 0, 0);
    add(4'h5, 0, 3'd1, 1, 1, 1, 0, 0, 0);
    add(4'h9, 0, 3'd2, 1, 1, 1, 0, 1, 0);
    add(4'hc, 0, 3'd3, 1, 1, 1, 0, 0, 0);
    add(4'h6, 1, 3'd7, 1, 0, 0, 1, 0, 0);
    add_cycle(0, 0, 0, 1, 1, 0, 1, 0);
    add_cycle(0, 1, 0, 1, 1, 1, 1, 0);
    add_cycle(1, 1, 1, 0, 0, 0, 0, 1);
    add(4'h3, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(4'h5, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(4'h9, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(4'h0, 1, 3'd7, 1, 0, 0, 0, 0, 0);
    add_cycle(0, 0, 0, 1, 1, 0, 1, 0);
    add_cycle(0, 1, 0, 1, 1, 1, 1, 0);
    add_cycle(1, 1, 1, 1, 1, 1, 1, 0);
    add(4'h3, 0, 3'd0, 1, 1, 1, 0, 0, 0);
    foreach (tbl[i]) run(tbl[i]);
    // reset asserted in the middle of A2
    sync = 1'b0;
    d_in = 4'h5;
    phase(0);
    chk("a2_entry", subcycle, 3'd1);
    phase(1);
    @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", {hot, subcycle, tracking, locked, addr, addr_valid, inst, inst_valid, sync_error}, 0);
    chk("async_reset_l1", {hot_b, subcycle_b, tracking_b, locked_b, addr_b, addr_valid_b, inst_b, inst_valid_b, sync_error_b}, 0);
    for (int k = 2; k < 8; k++) phase(k);
    @(negedge sysclk);
    reset = 1'b0;
    tbl.delete();
    add(4'h9, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(4'hc, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(4'h6, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    add(4'h0, 1, 3'd7, 1, 0, 0, 0, 0, 0);
    add_cycle(0, 0, 0, 1, 1, 0, 1, 0);
    add_cycle(0, 1, 0, 1, 1, 1, 1, 0);
    add_cycle(1, 1, 1, 1, 1, 1, 1, 0);
    foreach (tbl[i]) run(tbl[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
